// File: rtl/find_controller_if.sv
// Result stream from find_controller to the host-side register/bus logic.
// A word moves when o_valid and i_ready are both high on a rising clock edge.
// o_last marks the final word of a result.
interface find_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_last;
  logic                  i_ready;

  modport master (output o_data, output o_valid, output o_last, input i_ready);
  modport slave  (input  o_data, input  o_valid, input  o_last, output i_ready);
endinterface

// File: rtl/find_controller.sv
// Run controller and result serializer for one find search core.
// While idle, the core is held in reset. A start request gives the core a
// clean reset of RST_CYCLES cycles and then runs it. The block counts the
// cycles until the core reports done. It then latches the best sequence and
// its energy, and streams three words: seq, energy, cycle count (last).
// Optional feature macro: FIND_CTRL_TIMEOUT_EN aborts a run after
// TIMEOUT_CYCLES and flags the result with o_timeout.
module find_controller #(
  parameter int SEQ_WIDTH      = 8,
  parameter int E_WIDTH        = 20,
  parameter int CNT_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_find_rst,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [E_WIDTH-1:0]   i_e,
  input  logic                 i_done,
  output logic                 o_timeout,
  find_controller_if.master    m_out
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [RCW-1:0]        r_rst_cnt, w_rst_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [E_WIDTH-1:0]    r_e, w_e_nxt;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_find_rst, w_find_rst_nxt;
  logic                  w_xfer;

  // Core outputs, registered once. Done is only taken while RUN is active, so
  // a stale done left over from the previous run (seen during RESET) is dropped.
  logic                  r_done;
  logic [SEQ_WIDTH-1:0]  r_seq_in;
  logic [E_WIDTH-1:0]    r_e_in;

`ifdef FIND_CTRL_TIMEOUT_EN
  logic                  r_timeout, w_timeout_nxt;
`else
  logic                  w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  assign w_xfer    = r_valid & m_out.i_ready;
  // Run-length counter saturates at all-ones instead of wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

  // Input capture stage for the core's done flag and its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_seq_in <= '0;
      r_e_in   <= '0;
    end else begin
      r_done   <= (r_state == S_RUN) & i_done;
      r_seq_in <= i_seq;
      r_e_in   <= i_e;
    end
  end

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so the outputs never glitch.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_cnt_nxt     = r_cnt;
    w_e_nxt       = r_e;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_last_nxt    = r_last;
`ifdef FIND_CTRL_TIMEOUT_EN
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (i_start) begin
          w_state_nxt   = S_RESET;
          w_rst_cnt_nxt = '0;
`ifdef FIND_CTRL_TIMEOUT_EN
          w_timeout_nxt = 1'b0;
`endif
        end
      end
      S_RESET: begin
        if (r_rst_cnt == RCW'(RST_CYCLES)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RCW'(1);
        end
      end
      S_RUN: begin
        // Done takes priority over the timeout threshold.
        if (r_done) begin
          w_state_nxt = S_EMIT;
          w_e_nxt     = r_e_in;
          w_idx_nxt   = 2'd0;
          w_data_nxt  = DATA_WIDTH'(r_seq_in);
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
        end
`ifdef FIND_CTRL_TIMEOUT_EN
        else if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
          w_state_nxt   = S_EMIT;
          w_e_nxt       = r_e_in;
          w_idx_nxt     = 2'd0;
          w_data_nxt    = DATA_WIDTH'(r_seq_in);
          w_valid_nxt   = 1'b1;
          w_last_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end
`endif
        else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_EMIT: begin
        // Advance only on a transfer; otherwise data/last hold.
        if (w_xfer) begin
          case (r_idx)
            2'd0: begin
              w_idx_nxt  = 2'd1;
              w_data_nxt = DATA_WIDTH'(r_e);
            end
            2'd1: begin
              w_idx_nxt  = 2'd2;
              w_data_nxt = DATA_WIDTH'(r_cnt);
              w_last_nxt = 1'b1;
            end
            default: begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = 2'd0;
              w_data_nxt  = '0;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_find_rst_nxt = (w_state_nxt != S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rst_cnt  <= '0;
      r_cnt      <= '0;
      r_e        <= '0;
      r_idx      <= 2'd0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_find_rst <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_e        <= w_e_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= w_busy_nxt;
      r_find_rst <= w_find_rst_nxt;
    end
  end

`ifdef FIND_CTRL_TIMEOUT_EN
  // Abort flag for the current result. It is cleared when the next run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timeout <= 1'b0;
    else        r_timeout <= w_timeout_nxt;
  end
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy        = r_busy;
  assign o_find_rst    = r_find_rst;
  assign m_out.o_data  = r_data;
  assign m_out.o_valid = r_valid;
  assign m_out.o_last  = r_last;

endmodule

// File: tb/tb_find_controller.sv
// Self-checking bench for find_controller. Expected result words are queued
// when done (or a timeout) is provoked, and are popped and compared as the
// DUT transfers them. Edge numbers count from the start edge (edge 0).
module tb_find_controller;
  localparam int SW = 8, EW = 20, CW = 32, DW = 32, RC = 4, TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_done = 1'b0;
  logic [SW-1:0] i_seq = '0;
  logic [EW-1:0] i_e = '0;
  logic          o_busy, o_find_rst, o_timeout;

  find_controller_if #(.DATA_WIDTH(DW)) bus();

  find_controller #(
    .SEQ_WIDTH(SW), .E_WIDTH(EW), .CNT_WIDTH(CW), .DATA_WIDTH(DW),
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy),
    .o_find_rst(o_find_rst), .i_seq(i_seq), .i_e(i_e), .i_done(i_done),
    .o_timeout(o_timeout), .m_out(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [DW-1:0] data; logic last;} word_t;
  word_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Stream monitor. Sampling happens on the falling edge; the bench drives on
  // the rising edge, so the values seen here are the ones the next rising edge
  // samples.
  logic          p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [DW-1:0] p_data = '0;
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      p_vld = 1'b0;
      p_rdy = 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== p_data || bus.o_last !== p_last) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   bus.o_valid, bus.o_data, bus.o_last, p_data, p_last);
        end
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got data=%h last=%b required no transfer", bus.o_data, bus.o_last);
        end else begin
          w = exp_q.pop_front();
          if (bus.o_data !== w.data || bus.o_last !== w.last) begin
            errors++;
            $display("FAIL word: got data=%h last=%b required data=%h last=%b",
                     bus.o_data, bus.o_last, w.data, w.last);
          end
        end
      end
      p_vld  = bus.o_valid;
      p_rdy  = bus.i_ready;
      p_data = bus.o_data;
      p_last = bus.o_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst_vals(input string nm);
    checks++;
    if ({o_busy, o_find_rst, bus.o_valid, bus.o_last, o_timeout, bus.o_data} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL %s: busy=%b find_rst=%b valid=%b last=%b timeout=%b data=%h required 0 1 0 0 0 0",
               nm, o_busy, o_find_rst, bus.o_valid, bus.o_last, o_timeout, bus.o_data);
    end
  endtask

  // Pulse start at edge 0; return just after edge RC+1 (core reset released).
  task automatic start_job();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b required 1", o_busy); end
    repeat (RC) step();
    checks++;
    if (o_find_rst !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b required 1", o_find_rst); end
    step();
    checks++;
    if (o_find_rst !== 1'b0) begin errors++; $display("FAIL rst_fall: got %b required 0", o_find_rst); end
  endtask

  // Waits pre steps, then has done sampled on the next edge (edge N).
  // Returns just after edge N+1, when word 0 must be valid.
  task automatic finish_job(input logic [SW-1:0] s, input logic [EW-1:0] e,
                            input int pre, input int cnt);
    repeat (pre) step();
    i_done = 1'b1;
    i_seq  = s;
    i_e    = e;
    exp_q.push_back('{data: DW'(s),   last: 1'b0});
    exp_q.push_back('{data: DW'(e),   last: 1'b0});
    exp_q.push_back('{data: DW'(cnt), last: 1'b1});
    step();
    i_done = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b required 0", bus.o_valid); end
    step();
    checks++;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL valid_rise: got %b required 1", bus.o_valid); end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (o_busy !== 1'b0 && n < limit) begin step(); n++; end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_timeout: busy=%b after %0d cycles required 0", o_busy, limit); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_words: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) step();
    check_rst_vals("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({o_find_rst, o_busy, bus.o_valid} !== 3'b100) begin
        errors++;
        $display("FAIL idle_%0d: find_rst=%b busy=%b valid=%b required 1 0 0", i, o_find_rst, o_busy, bus.o_valid);
      end
    end
  endtask

  task automatic test_basic();
    bus.i_ready = 1'b1;
    start_job();
    finish_job(8'hA5, 20'h0001C, 99, 100);
    step();
    step();
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_emit: got %b required 1", o_busy); end
    step();
    checks++;
    if ({o_busy, o_find_rst, bus.o_valid, o_timeout} !== 4'b0100) begin
      errors++;
      $display("FAIL basic_end: busy=%b find_rst=%b valid=%b timeout=%b required 0 1 0 0",
               o_busy, o_find_rst, bus.o_valid, o_timeout);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_words: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b1;
    start_job();
    finish_job(8'h5A, 20'hABCDE, 36, 37);
    step();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== DW'(20'hABCDE)) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b data=%h required 1 %h", i, bus.o_valid, bus.o_data, DW'(20'hABCDE));
      end
    end
    bus.i_ready = 1'b1;
    wait_idle(10);
  endtask

  task automatic test_ignored();
    bus.i_ready = 1'b1;
    i_done  = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (RC + 1) step();
    i_done = 1'b0;
    checks++;
    if (o_find_rst !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_done: find_rst=%b valid=%b required 0 0", o_find_rst, bus.o_valid);
    end
    repeat (10) step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_find_rst !== 1'b0) begin
      errors++;
      $display("FAIL run_start: busy=%b find_rst=%b required 1 0", o_busy, o_find_rst);
    end
    finish_job(8'h3F, 20'h12345, 18, 30);
    step();
    step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_find_rst !== 1'b1) begin
      errors++;
      $display("FAIL last_start: busy=%b find_rst=%b required 0 1", o_busy, o_find_rst);
    end
    step();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL no_restart: busy=%b required 0", o_busy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignored_words: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    bus.i_ready = 1'b1;
    start_job();
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check_rst_vals("reset_run");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_job();
    finish_job(8'h11, 20'h00022, 14, 15);
    step();
    bus.i_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_rst_vals("reset_emit");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    start_job();
    finish_job(8'hC3, 20'h0F00D, 19, 20);
    wait_idle(10);
  endtask

`ifdef FIND_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bus.i_ready = 1'b1;
    i_seq = 8'h3C;
    i_e   = 20'h00777;
    exp_q.push_back('{data: DW'(8'h3C),     last: 1'b0});
    exp_q.push_back('{data: DW'(20'h00777), last: 1'b0});
    exp_q.push_back('{data: DW'(TO),        last: 1'b1});
    start_job();
    while (bus.o_valid !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (bus.o_valid !== 1'b1 || o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_emit: valid=%b timeout=%b required 1 1", bus.o_valid, o_timeout);
    end
    wait_idle(10);
    checks++;
    if (o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b required 1", o_timeout); end
    start_job();
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b required 0", o_timeout); end
    finish_job(8'h01, 20'h00002, TO - 1, TO);
    checks++;
    if (o_timeout !== 1'b0) begin errors++; $display("FAIL done_wins: got %b required 0", o_timeout); end
    wait_idle(10);
  endtask
`endif

  initial begin
    bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored();
    test_mid_reset();
`ifdef FIND_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
